// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and memory-port signals around the shared memory port.
// The arbiter takes the slave view; requesters and the memory take the master view.
interface mem_port_arbiter_if #(
    parameter int XLEN = 32
);
    logic            i_req;
    logic [XLEN-1:0] i_addr;
    logic            i_flush;
    logic            i_gnt;
    logic            i_rvalid;
    logic [XLEN-1:0] i_rdata;
    logic            i_pause;

    logic            d_req;
    logic            d_we;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic [3:0]      d_wstrb;
    logic            d_gnt;
    logic            d_rvalid;
    logic [XLEN-1:0] d_rdata;

    logic            m_req;
    logic            m_we;
    logic [XLEN-1:0] m_addr;
    logic [XLEN-1:0] m_wdata;
    logic [3:0]      m_wstrb;
    logic            m_ack;
    logic [XLEN-1:0] m_rdata;

    modport slave (
        input  i_req, i_addr, i_flush,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  m_ack, m_rdata,
        output i_gnt, i_rvalid, i_rdata, i_pause,
        output d_gnt, d_rvalid, d_rdata,
        output m_req, m_we, m_addr, m_wdata, m_wstrb
    );

    modport master (
        output i_req, i_addr, i_flush,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        output m_ack, m_rdata,
        input  i_gnt, i_rvalid, i_rdata, i_pause,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_req, m_we, m_addr, m_wdata, m_wstrb
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction
// outstanding; data has priority but fetch is guaranteed a slot every MAX_D_STREAK grants.
module mem_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    mem_port_arbiter_if.slave       bus
);
    typedef enum logic [1:0] {
        IDLE,
        I_BUSY,
        D_BUSY
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    state_t     state;
    logic [3:0] streak;
    logic       flush_mark;
    logic       i_rvalid_q;
    logic       fetch_pick;
    logic       data_pick;

    // Grants are decided combinationally in IDLE so gnt lands in the cycle req is sampled.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        fetch_pick = 1'b0;
        data_pick  = 1'b0;
        if (state == IDLE && !rst) begin
            if (bus.i_req && (!bus.d_req || streak == STREAK_MAX)) begin
                fetch_pick = 1'b1;
            end else if (bus.d_req) begin
                data_pick = 1'b1;
            end
        end
    end

    assign bus.i_gnt    = fetch_pick;
    assign bus.d_gnt    = data_pick;
    // A flush arriving together with the registered pulse still kills it.
    assign bus.i_rvalid = i_rvalid_q & ~bus.i_flush;
    assign bus.i_pause  = bus.i_req & ~bus.i_rvalid;

    // NOTE: async reset clears m_req at once; the abandoned transaction is never replayed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            streak      <= 4'd0;
            flush_mark  <= 1'b0;
            i_rvalid_q  <= 1'b0;
            bus.d_rvalid <= 1'b0;
            bus.i_rdata <= {XLEN{1'b0}};
            bus.d_rdata <= {XLEN{1'b0}};
            bus.m_req   <= 1'b0;
            bus.m_we    <= 1'b0;
            bus.m_addr  <= {XLEN{1'b0}};
            bus.m_wdata <= {XLEN{1'b0}};
            bus.m_wstrb <= 4'b0000;
        end else begin
            i_rvalid_q   <= 1'b0;
            bus.d_rvalid <= 1'b0;

            if (!bus.i_req || fetch_pick) begin
                streak <= 4'd0;
            end else if (data_pick && streak != STREAK_MAX) begin
                streak <= streak + 4'd1;
            end

            case (state)
                IDLE: begin
                    if (fetch_pick) begin
                        bus.m_req   <= 1'b1;
                        bus.m_we    <= 1'b0;
                        bus.m_addr  <= bus.i_addr;
                        bus.m_wdata <= {XLEN{1'b0}};
                        bus.m_wstrb <= 4'b0000;
                        flush_mark  <= bus.i_flush;
                        state       <= I_BUSY;
                    end else if (data_pick) begin
                        bus.m_req   <= 1'b1;
                        bus.m_we    <= bus.d_we;
                        bus.m_addr  <= bus.d_addr;
                        bus.m_wdata <= bus.d_wdata;
                        bus.m_wstrb <= bus.d_we ? bus.d_wstrb : 4'b0000;
                        state       <= D_BUSY;
                    end
                end

                I_BUSY: begin
                    if (bus.i_flush) begin
                        flush_mark <= 1'b1;
                    end
                    if (bus.m_ack) begin
                        bus.m_req  <= 1'b0;
                        flush_mark <= 1'b0;
                        state      <= IDLE;
                        // A flushed fetch completes on the bus but returns nothing.
                        if (!(flush_mark || bus.i_flush)) begin
                            i_rvalid_q  <= 1'b1;
                            bus.i_rdata <= bus.m_rdata;
                        end
                    end
                end

                D_BUSY: begin
                    if (bus.m_ack) begin
                        bus.m_req    <= 1'b0;
                        bus.d_rvalid <= 1'b1;
                        bus.d_rdata  <= bus.m_we ? {XLEN{1'b0}} : bus.m_rdata;
                        state        <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: requester tasks push expected responses into a
// scoreboard, a negedge monitor pops and compares them whenever an rvalid appears.
module tb_mem_port_arbiter;
    typedef struct {
        bit          is_fetch;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    int   ack_delay;
    exp_t sb[$];
    byte  glog[$];
    logic [31:0] last_fetch;

    mem_port_arbiter_if #(.XLEN(32)) bus ();

    mem_port_arbiter #(.XLEN(32), .MAX_D_STREAK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0000_0013 : (a ^ 32'h5A5A_0000);
    endfunction

    // Memory: acks ack_delay cycles after m_req rises, rdata from mem_word.
    initial begin
        int cnt;
        cnt = 0;
        bus.m_ack   = 1'b0;
        bus.m_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.m_req) begin
                if (cnt == ack_delay) begin
                    bus.m_ack   = 1'b1;
                    bus.m_rdata = mem_word(bus.m_addr);
                    cnt = 0;
                end else begin
                    bus.m_ack = 1'b0;
                    cnt++;
                end
            end else begin
                bus.m_ack = 1'b0;
                cnt = 0;
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.i_rvalid && bus.d_rvalid) begin
                check("rvalid_overlap", {bus.i_rvalid, bus.d_rvalid}, 2'b01);
            end else if (bus.i_rvalid || bus.d_rvalid) begin
                if (sb.size() == 0) begin
                    check("unexpected_rvalid", {bus.i_rvalid, bus.d_rvalid}, 2'b00);
                end else begin
                    e = sb.pop_front();
                    check("rvalid_owner", bus.i_rvalid, e.is_fetch);
                    check(e.is_fetch ? "i_rdata" : "d_rdata",
                          e.is_fetch ? bus.i_rdata : bus.d_rdata, e.data);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called and returns at posedge+1. Returns how many cycles req waited before gnt.
    task automatic do_fetch(input logic [31:0] addr, input bit flush, output int waited);
        bus.i_req  = 1'b1;
        bus.i_addr = addr;
        waited = 0;
        forever begin
            @(negedge clk);
            if (bus.i_gnt || waited >= 60) break;
            waited++;
        end
        if (!bus.i_gnt) check("i_gnt_timeout", bus.i_gnt, 1'b1);
        if (!flush) begin
            sb.push_back('{is_fetch: 1'b1, data: mem_word(addr)});
            last_fetch = mem_word(addr);
        end
        glog.push_back("I");
        @(posedge clk);
        #1;
        bus.i_req   = 1'b0;
        bus.i_flush = flush;
        @(negedge clk);
        check("fetch_m_req", bus.m_req, 1'b1);
        check("fetch_m_addr", bus.m_addr, addr);
        check("fetch_m_we", bus.m_we, 1'b0);
        check("fetch_m_wstrb", bus.m_wstrb, 4'b0000);
        @(posedge clk);
        #1;
        bus.i_flush = 1'b0;
    endtask

    task automatic do_data(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb);
        int waited;
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        bus.d_wstrb = wstrb;
        waited = 0;
        forever begin
            @(negedge clk);
            if (bus.d_gnt || waited >= 60) break;
            waited++;
        end
        if (!bus.d_gnt) check("d_gnt_timeout", bus.d_gnt, 1'b1);
        sb.push_back('{is_fetch: 1'b0, data: we ? 32'h0 : mem_word(addr)});
        glog.push_back("D");
        @(posedge clk);
        #1;
        bus.d_req = 1'b0;
        @(negedge clk);
        check("data_m_req", bus.m_req, 1'b1);
        check("data_m_addr", bus.m_addr, addr);
        check("data_m_we", bus.m_we, we);
        check("data_m_wstrb", bus.m_wstrb, we ? wstrb : 4'b0000);
        if (we) check("data_m_wdata", bus.m_wdata, wdata);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int    w;
        string pat;
        n_cmp = 0;
        n_fail = 0;
        ack_delay = 0;
        last_fetch = '0;
        rst = 1'b1;
        bus.i_req = 1'b1;
        bus.i_addr = '0;
        bus.i_flush = 1'b0;
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        bus.d_addr = '0;
        bus.d_wdata = '0;
        bus.d_wstrb = '0;

        // Reset state, with i_req high to see i_pause follow it and gnt held off.
        repeat (2) @(negedge clk);
        check("rst_i_gnt", bus.i_gnt, 1'b0);
        check("rst_i_pause", bus.i_pause, 1'b1);
        check("rst_m_req", bus.m_req, 1'b0);
        check("rst_m_addr", bus.m_addr, 32'h0);
        check("rst_rvalids", {bus.i_rvalid, bus.d_rvalid}, 2'b00);
        check("rst_rdata", {bus.i_rdata, bus.d_rdata}, 64'h0);
        @(posedge clk);
        #1;
        bus.i_req = 1'b0;
        rst = 1'b0;
        idle(2);

        // Single fetch, ack in the m_req cycle: gnt N, m_req N+1, rvalid N+2.
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h8000_0000;
        @(negedge clk);
        check("t1_i_gnt_N", bus.i_gnt, 1'b1);
        check("t1_pause_N", bus.i_pause, 1'b1);
        check("t1_m_req_N", bus.m_req, 1'b0);
        sb.push_back('{is_fetch: 1'b1, data: 32'h0000_0013});
        @(posedge clk);
        #1;
        bus.i_req = 1'b0;
        @(negedge clk);
        check("t1_m_req_N1", bus.m_req, 1'b1);
        check("t1_m_addr_N1", bus.m_addr, 32'h8000_0000);
        check("t1_i_gnt_N1", bus.i_gnt, 1'b0);
        @(negedge clk);
        check("t1_i_rvalid_N2", bus.i_rvalid, 1'b1);
        check("t1_i_rdata_N2", bus.i_rdata, 32'h0000_0013);
        check("t1_pause_N2", bus.i_pause, 1'b0);
        check("t1_m_req_N2", bus.m_req, 1'b0);
        @(posedge clk);
        #1;
        last_fetch = 32'h0000_0013;
        idle(3);

        // Concurrent fetch and load, 3-cycle ack: data first, then fetch.
        ack_delay = 3;
        glog.delete();
        fork
            do_fetch(32'h0000_3000, 1'b0, w);
            do_data(1'b0, 32'h0000_0100, 32'h0, 4'b1111);
        join
        idle(10);
        check("t2_grants", glog.size(), 2);
        if (glog.size() == 2) begin
            check("t2_first", glog[0], "D");
            check("t2_second", glog[1], "I");
        end

        // Streak limit: 8 loads against 2 fetches gives D,D,D,D,I,D,D,D,D,I.
        ack_delay = 1;
        glog.delete();
        fork
            begin
                int wf;
                for (int j = 0; j < 2; j++) do_fetch(32'h0000_1000 + 32'(4 * j), 1'b0, wf);
            end
            begin
                for (int j = 0; j < 8; j++) do_data(1'b0, 32'h0000_0200 + 32'(4 * j), 32'h0, 4'b0);
            end
        join
        idle(6);
        pat = "DDDDIDDDDI";
        check("t3_grants", glog.size(), 10);
        for (int j = 0; j < 10 && j < glog.size(); j++) begin
            check($sformatf("t3_order_%0d", j), glog[j], pat[j]);
        end

        // Store: write strobes pass through, completion carries zero data.
        ack_delay = 0;
        do_data(1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'b0011);
        idle(4);

        // Flush one cycle after grant: bus access completes, no i_rvalid, old rdata kept.
        ack_delay = 2;
        do_fetch(32'h0000_0600, 1'b1, w);
        idle(6);
        check("t5_m_req_done", bus.m_req, 1'b0);
        check("t5_i_rdata_held", bus.i_rdata, last_fetch);
        do_fetch(32'h0000_0604, 1'b0, w);
        idle(6);

        // Reset during D_BUSY with m_req high: m_req drops at once, nothing returned.
        ack_delay = 5;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h0000_0400;
        w = 0;
        forever begin
            @(negedge clk);
            if (bus.d_gnt || w >= 60) break;
            w++;
        end
        check("t6_d_gnt", bus.d_gnt, 1'b1);
        @(posedge clk);
        #1;
        bus.d_req = 1'b0;
        #2;
        check("t6_m_req_before", bus.m_req, 1'b1);
        rst = 1'b1;
        #1;
        check("t6_m_req_async", bus.m_req, 1'b0);
        check("t6_rvalids", {bus.i_rvalid, bus.d_rvalid}, 2'b00);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(8);
        ack_delay = 0;
        do_fetch(32'h0000_0700, 1'b0, w);
        check("t6_grant_from_idle", w, 0);
        idle(5);

        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
